uwasic_onboarding_hurayrah_butt: RTL and testbench

- Top-level TinyTapeout user block: an SPI-writable register file driving 16 outputs.
- Each output can be held low, driven static high, or driven by a shared PWM waveform.
- The SPI slave lives on ui_in[2:0].
- Outputs 7:0 drive uo_out; outputs 15:8 drive uio_out, which is permanently enabled.

---
 rtl/uwasic_onboarding_hurayrah_butt_pkg.sv | 23 ++
 rtl/uwasic_onboarding_hurayrah_butt_if.sv | 24 ++
 rtl/uwasic_onboarding_hurayrah_butt_spi_peripheral.sv | 91 +++++++++
 rtl/uwasic_onboarding_hurayrah_butt.sv | 64 ++++++
 tb/tb_uwasic_onboarding_hurayrah_butt.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/uwasic_onboarding_hurayrah_butt_pkg.sv
// rtl/uwasic_onboarding_hurayrah_butt_pkg.sv - shared constants and frame type for the SPI PWM block
// Purpose: register addresses, frame geometry and default PWM divider.
// Ports: none (package).
package uwasic_pkg;

  localparam int FRAME_BITS      = 16;
  localparam int NUM_REGS        = 5;
  localparam int CLK_DIV_DEFAULT = 3333;

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_DUTY      = 7'h04;

  // Shifted in MSB first, so rw lands in bit 15 once 16 bits have arrived.
  typedef struct packed {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] data;
  } spi_frame_t;

endpackage

// File: rtl/uwasic_onboarding_hurayrah_butt_if.sv
// rtl/uwasic_onboarding_hurayrah_butt_if.sv - TinyTapeout user pin bundle
// Purpose: groups the TinyTapeout user pins into one port.
// Ports: ena, ui_in[7:0], uio_in[7:0] into the design; uo_out[7:0],
//        uio_out[7:0], uio_oe[7:0] out of the design.
interface uwasic_onboarding_hurayrah_butt_if;

  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );

endinterface

// File: rtl/uwasic_onboarding_hurayrah_butt_spi_peripheral.sv
// rtl/uwasic_onboarding_hurayrah_butt_spi_peripheral.sv - SPI write-only slave with five control registers
// Purpose: synchronizes SCLK/COPI/nCS, shifts in 16-bit mode-0 frames and
//          commits valid writes into the register file.
// Ports: clk, rst_n (async active-low); sclk, copi, ncs raw pad inputs;
//        en_out[15:0], en_pwm[15:0], duty[7:0] register contents.
module spi_peripheral
  import uwasic_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sclk,
  input  logic        copi,
  input  logic        ncs,
  output logic [15:0] en_out,
  output logic [15:0] en_pwm,
  output logic [7:0]  duty
);

  logic [1:0] sclk_sync;
  logic [1:0] copi_sync;
  logic [1:0] ncs_sync;
  logic       sclk_q;
  logic       ncs_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      copi_sync <= '0;
      ncs_sync  <= '0;
      sclk_q    <= 1'b0;
      ncs_q     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], sclk};
      copi_sync <= {copi_sync[0], copi};
      ncs_sync  <= {ncs_sync[0], ncs};
      sclk_q    <= sclk_sync[1];
      ncs_q     <= ncs_sync[1];
    end
  end

  logic sclk_rise;
  logic ncs_fall;
  logic ncs_rise;

  assign sclk_rise = sclk_sync[1] & ~sclk_q;
  assign ncs_fall  = ~ncs_sync[1] & ncs_q;
  assign ncs_rise  = ncs_sync[1] & ~ncs_q;

  spi_frame_t frame;
  logic [4:0] bit_cnt;
  // bit_cnt stops at 16; a 17th edge sets overrun so long frames are rejected.
  logic       overrun;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame   <= '0;
      bit_cnt <= '0;
      overrun <= 1'b0;
    end else if (ncs_fall) begin
      frame   <= '0;
      bit_cnt <= '0;
      overrun <= 1'b0;
    end else if (sclk_rise && !ncs_sync[1]) begin
      frame <= spi_frame_t'({frame[FRAME_BITS-2:0], copi_sync[1]});
      if (bit_cnt == 5'(FRAME_BITS)) overrun <= 1'b1;
      else                           bit_cnt <= bit_cnt + 5'd1;
    end
  end

  logic commit;
  assign commit = ncs_rise && (bit_cnt == 5'(FRAME_BITS)) && !overrun &&
                  frame.rw && (frame.addr < 7'(NUM_REGS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_out <= '0;
      en_pwm <= '0;
      duty   <= '0;
    end else if (commit) begin
      case (frame.addr)
        ADDR_EN_OUT_LO: en_out[7:0]  <= frame.data;
        ADDR_EN_OUT_HI: en_out[15:8] <= frame.data;
        ADDR_EN_PWM_LO: en_pwm[7:0]  <= frame.data;
        ADDR_EN_PWM_HI: en_pwm[15:8] <= frame.data;
        ADDR_DUTY:      duty         <= frame.data;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uwasic_onboarding_hurayrah_butt.sv
// rtl/uwasic_onboarding_hurayrah_butt.sv - TinyTapeout top: SPI-programmed 16-channel static/PWM output driver
// Purpose: shared PWM generator plus per-output off/high/PWM selection.
// Ports: clk, rst_n (async active-low); bus (slave side of the pin bundle):
//        ui_in[0]=SCLK, ui_in[1]=COPI, ui_in[2]=nCS, uo_out=out[7:0],
//        uio_out=out[15:8], uio_oe=8'hFF; ena, uio_in and ui_in[7:3] unused.
module uwasic_onboarding_hurayrah_butt
  import uwasic_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input logic                           clk,
  input logic                           rst_n,
  uwasic_onboarding_hurayrah_butt_if.slave bus
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int TH_W  = CNT_W + 8;

  logic [15:0] en_out;
  logic [15:0] en_pwm;
  logic [7:0]  duty;

  spi_peripheral u_spi (
    .clk    (clk),
    .rst_n  (rst_n),
    .sclk   (bus.ui_in[0]),
    .copi   (bus.ui_in[1]),
    .ncs    (bus.ui_in[2]),
    .en_out (en_out),
    .en_pwm (en_pwm),
    .duty   (duty)
  );

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             count <= '0;
    else if (count == CNT_W'(CLK_DIV - 1))  count <= '0;
    else                                    count <= count + 1'b1;
  end

  logic [TH_W-1:0] thresh;
  assign thresh = TH_W'((TH_W'(duty) * TH_W'(CLK_DIV)) >> 8);

  // Registered so outputs only ever change on a clock edge.
  logic pwm_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              pwm_q <= 1'b0;
    else if (duty == 8'hFF)  pwm_q <= 1'b1;
    else                     pwm_q <= (TH_W'(count) < thresh);
  end

  logic [15:0] out;
  assign out = en_out & (~en_pwm | {16{pwm_q}});

  assign bus.uo_out  = out[7:0];
  assign bus.uio_out = out[15:8];
  assign bus.uio_oe  = 8'hFF;

  logic unused_inputs;
  assign unused_inputs = &{1'b0, bus.ena, bus.uio_in, bus.ui_in[7:3]};

endmodule

// File: tb/tb_uwasic_onboarding_hurayrah_butt.sv
// tb/tb_uwasic_onboarding_hurayrah_butt.sv - scoreboard bench for the SPI PWM block
module tb_uwasic_onboarding_hurayrah_butt;

  localparam int CLK_DIV = 3333;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk = 1'b0;
  logic copi = 1'b0;
  logic ncs  = 1'b1;

  always #50 clk = ~clk;

  uwasic_onboarding_hurayrah_butt_if tt ();

  assign tt.ena    = 1'b1;
  assign tt.uio_in = 8'h00;
  assign tt.ui_in  = {5'b0, ncs, copi, sclk};

  uwasic_onboarding_hurayrah_butt #(.CLK_DIV(CLK_DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (tt)
  );

  typedef struct {
    string name;
    int    kind;   // 0: {uio_oe,uio_out,uo_out} snapshot, 1: uo_out[0] highs per period
    int    exp;
  } item_t;

  item_t sb[$];
  int req_cnt = 0;
  int done_cnt = 0;
  int vectors = 0;
  int miscompares = 0;

  initial begin : monitor
    item_t it;
    logic [23:0] act;
    int hi;
    forever begin
      wait (req_cnt > done_cnt);
      it = sb.pop_front();
      if (it.kind == 0) begin
        @(negedge clk);
        act = {tt.uio_oe, tt.uio_out, tt.uo_out};
        vectors++;
        if (act != it.exp[23:0]) begin
          miscompares++;
          $display("FAIL %s: got %h expected %h", it.name, act, it.exp[23:0]);
        end
      end else begin
        hi = 0;
        repeat (CLK_DIV) begin
          @(negedge clk);
          hi += int'(tt.uo_out[0]);
        end
        vectors++;
        if (hi != it.exp) begin
          miscompares++;
          $display("FAIL %s: got %0d high cycles expected %0d", it.name, hi, it.exp);
        end
      end
      done_cnt++;
    end
  end

  task automatic wait_done(input string name);
    for (int i = 0; i < 10000 && done_cnt < req_cnt; i++) @(negedge clk);
    if (done_cnt < req_cnt) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: monitor timeout, got %0d done expected %0d", name, done_cnt, req_cnt);
    end
  endtask

  task automatic expect_state(input string name, input logic [23:0] e);
    sb.push_back('{name, 0, int'(e)});
    req_cnt++;
    wait_done(name);
  endtask

  task automatic expect_pwm(input string name, input int e);
    sb.push_back('{name, 1, e});
    req_cnt++;
    wait_done(name);
  endtask

  task automatic spi_send(input logic [31:0] bits, input int n, input bit close);
    ncs = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = n - 1; i >= 0; i--) begin
      sclk = 1'b0;
      copi = bits[i];
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      repeat (4) @(negedge clk);
    end
    if (close) begin
      sclk = 1'b0;
      repeat (4) @(negedge clk);
      ncs = 1'b1;
    end
  endtask

  // Sample lands 4 clocks after the raw nCS rising edge.
  task automatic frame_check(input logic [15:0] f, input string name, input logic [23:0] e);
    spi_send({16'h0, f}, 16, 1'b1);
    repeat (3) @(negedge clk);
    expect_state(name, e);
  endtask

  task automatic bad_frame(input logic [31:0] bits, input int n, input string name, input logic [23:0] e);
    spi_send(bits, n, 1'b1);
    repeat (6) @(negedge clk);
    expect_state(name, e);
  endtask

  initial begin : watchdog
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got no finish expected finish within 60000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    repeat (3) @(negedge clk);
    expect_state("reset", 24'hFF0000);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    expect_state("idle_100", 24'hFF0000);

    frame_check(16'h80F0, "en_out_lo_F0", 24'hFF00F0);
    frame_check(16'h81CC, "en_out_hi_CC", 24'hFFCCF0);
    frame_check(16'h8001, "en_out_lo_01", 24'hFFCC01);
    frame_check(16'h8201, "en_pwm_lo_01", 24'hFFCC00);

    spi_send(32'h8480, 16, 1'b1);
    repeat (6) @(negedge clk);
    expect_pwm("duty_80", 1666);
    spi_send(32'h8400, 16, 1'b1);
    repeat (6) @(negedge clk);
    expect_pwm("duty_00", 0);
    spi_send(32'h84FF, 16, 1'b1);
    repeat (6) @(negedge clk);
    expect_pwm("duty_FF", CLK_DIV);
    expect_state("duty_FF_state", 24'hFFCC01);

    bad_frame(32'h000000FF, 16, "read_frame", 24'hFFCC01);
    bad_frame(32'h0000B0FF, 16, "addr_30", 24'hFFCC01);
    bad_frame(32'h000085FF, 16, "addr_05", 24'hFFCC01);
    bad_frame(32'h0000080F, 12, "short_12", 24'hFFCC01);
    bad_frame(32'h000080FF, 20, "long_20", 24'hFFCC01);

    spi_send(32'h80, 8, 1'b0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    ncs  = 1'b1;
    sclk = 1'b0;
    rst_n = 1'b1;
    expect_state("mid_frame_reset", 24'hFF0000);
    repeat (4) @(negedge clk);
    frame_check(16'h80AA, "after_reset_AA", 24'hFF00AA);

    spi_send(32'h8155, 16, 1'b1);
    repeat (4) @(negedge clk);
    frame_check(16'h800F, "back_to_back", 24'hFF550F);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
